// File: rtl/bbox_rasterizer_pkg.sv
// Shared types for the column-slice triangle rasterizer: task and pixel
// records, the FSM state enum, the per-edge accumulator record and the
// operand selection used during multiply-based setup.
package bbox_rasterizer_pkg;

    // Edge accumulator width carried by edge_t; the top's EDGE_W must match.
    localparam int EDGE_W_DEF = 24;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } vertex_t;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } color_t;

    typedef struct packed {
        vertex_t     a;
        vertex_t     b;
        vertex_t     c;
        color_t      color;
        logic [15:0] depth;
    } object_t;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [7:0]  red;
        logic [7:0]  green;
        logic [7:0]  blue;
        logic [15:0] depth;
    } pixel_info_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_CHECK = 3'd2,
        S_SCAN  = 3'd3,
        S_DONE  = 3'd4
    } raster_state_t;

    // e: value at the current pixel, ecol: value at the top of the column,
    // dy: increment for y+1, dx: increment for x+1.
    typedef struct packed {
        logic signed [EDGE_W_DEF-1:0] e;
        logic signed [EDGE_W_DEF-1:0] ecol;
        logic signed [EDGE_W_DEF-1:0] dx;
        logic signed [EDGE_W_DEF-1:0] dy;
    } edge_t;

    typedef struct packed {
        logic signed [10:0] m0;
        logic signed [10:0] m1;
    } mul_ops_t;

    // Signed difference of two unsigned 10-bit coordinates.
    function automatic logic signed [10:0] sdiff(input logic [9:0] q, input logic [9:0] p);
        return $signed({1'b0, q}) - $signed({1'b0, p});
    endfunction

    function automatic logic [9:0] min3(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        logic [9:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [9:0] max3(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        logic [9:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Operands of product idx. Even products are the (qx-px)(ymin-py) term,
    // odd products the (qy-py)(xmin-px) term, for edges ab, bc, ca in order.
    function automatic mul_ops_t mul_operands(input object_t o, input logic [9:0] xmin,
                                              input logic [9:0] ymin, input logic [2:0] idx);
        mul_ops_t r;
        case (idx)
            3'd0:    begin r.m0 = sdiff(o.b.x, o.a.x); r.m1 = sdiff(ymin, o.a.y); end
            3'd1:    begin r.m0 = sdiff(o.b.y, o.a.y); r.m1 = sdiff(xmin, o.a.x); end
            3'd2:    begin r.m0 = sdiff(o.c.x, o.b.x); r.m1 = sdiff(ymin, o.b.y); end
            3'd3:    begin r.m0 = sdiff(o.c.y, o.b.y); r.m1 = sdiff(xmin, o.b.x); end
            3'd4:    begin r.m0 = sdiff(o.a.x, o.c.x); r.m1 = sdiff(ymin, o.c.y); end
            default: begin r.m0 = sdiff(o.a.y, o.c.y); r.m1 = sdiff(xmin, o.c.x); end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bbox_rasterizer_multiplier.sv
// 11x11 signed multiplier with a one-cycle start/valid handshake: the
// product of operands presented with start appears with valid next cycle.
module bbox_rasterizer_multiplier (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic signed [10:0] op_a,
    input  logic signed [10:0] op_b,
    output logic               valid,
    output logic signed [21:0] product
);

    // Register the product and flag it valid one cycle after start.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid   <= 1'b0;
            product <= '0;
        end else begin
            valid <= start;
            if (start) begin
                product <= op_a * op_b;
            end
        end
    end

endmodule

// File: rtl/bbox_rasterizer.sv
// Column-slice triangle rasterizer. Clips the triangle's bounding box to the
// owned column range, sets up the three edge functions with six sequential
// multiplies, then scans x-major emitting covered pixels through a one-entry
// output register.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. task_ready does not depend on task_valid; pix_out/pix_valid are
// held stable while pix_valid && !pix_ready (except on switch_buffer, which
// drops a pending pixel).
module bbox_rasterizer
    import bbox_rasterizer_pkg::*;
#(
    parameter int X_RANGE_START = 0,
    parameter int X_RANGE_END   = 29,
    parameter int HEIGHT        = 479,
    parameter int EDGE_W        = 24
) (
    input  logic          clock,
    input  logic          reset,
    input  object_t       task_in,
    input  logic          task_valid,
    output logic          task_ready,
    input  logic          switch_buffer,
    output pixel_info_t   pix_out,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          task_done,
    output logic          busy,
    output raster_state_t raster_state
);

    localparam logic [9:0] X_LO = 10'(X_RANGE_START);
    localparam logic [9:0] X_HI = 10'(X_RANGE_END);
    localparam logic [9:0] Y_HI = 10'(HEIGHT);

    raster_state_t state;
    object_t       obj;
    logic [9:0]    xmin, xmax, ymin, ymax, x, y;
    logic [2:0]    mul_idx;
    edge_t         edges [3];

    logic [9:0] in_xmin, in_xmax, in_ymin, in_ymax;
    logic       in_empty, accept;

    logic                     mul_start, mul_valid;
    logic signed [21:0]       mul_product;
    mul_ops_t                 ops;
    logic signed [EDGE_W-1:0] prod_ext;
    logic signed [EDGE_W-1:0] area2;

    logic       capture, cap_first, covered, out_free, advance, row_end, col_end;
    logic [1:0] cap_edge;
    vertex_t    p_in [3];
    vertex_t    q_in [3];

    assign task_ready   = (state == S_IDLE) && !switch_buffer && !reset;
    assign accept       = task_ready && task_valid;
    assign busy         = (state != S_IDLE);
    assign raster_state = state;

    // Clipped bounding box of the incoming task.
    always_comb begin
        in_xmin  = min3(task_in.a.x, task_in.b.x, task_in.c.x);
        in_xmax  = max3(task_in.a.x, task_in.b.x, task_in.c.x);
        in_ymin  = min3(task_in.a.y, task_in.b.y, task_in.c.y);
        in_ymax  = max3(task_in.a.y, task_in.b.y, task_in.c.y);
        if (in_xmin < X_LO) in_xmin = X_LO;
        if (in_xmax > X_HI) in_xmax = X_HI;
        if (in_ymax > Y_HI) in_ymax = Y_HI;
        in_empty = (in_xmin > in_xmax) || (in_ymin > Y_HI);
    end

    // Multiplier sequencing: product 0 is issued in the accept cycle from the
    // live task so that SETUP takes exactly six multiplier results.
    always_comb begin
        if (state == S_IDLE) begin
            ops = mul_operands(task_in, in_xmin, in_ymin, 3'd0);
        end else begin
            ops = mul_operands(obj, xmin, ymin, 3'(mul_idx + 3'd1));
        end
        capture   = (state == S_SETUP) && mul_valid;
        cap_edge  = mul_idx[2:1];
        cap_first = !mul_idx[0];
        mul_start = !switch_buffer && ((accept && !in_empty) || (capture && mul_idx != 3'd5));
        prod_ext  = {{(EDGE_W-22){mul_product[21]}}, mul_product};
    end

    bbox_rasterizer_multiplier multiplier (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .op_a    (ops.m0),
        .op_b    (ops.m1),
        .valid   (mul_valid),
        .product (mul_product)
    );

    // Coverage test and scan advance decision for the current pixel.
    always_comb begin
        covered  = (edges[0].e >= 0 && edges[1].e >= 0 && edges[2].e >= 0) ||
                   (edges[0].e <= 0 && edges[1].e <= 0 && edges[2].e <= 0);
        out_free = !pix_valid || pix_ready;
        advance  = (state == S_SCAN) && (!covered || out_free);
        row_end  = (y == ymax);
        col_end  = (x == xmax);
        area2    = edges[0].e + edges[1].e + edges[2].e;
    end

    // Vertex pairs (p, q) of edges ab, bc, ca from the incoming task.
    always_comb begin
        p_in[0] = task_in.a; q_in[0] = task_in.b;
        p_in[1] = task_in.b; q_in[1] = task_in.c;
        p_in[2] = task_in.c; q_in[2] = task_in.a;
    end

    for (genvar i = 0; i < 3; i++) begin : g_edge
        logic signed [10:0]       ddx, ddy;
        logic signed [EDGE_W-1:0] step_dy, step_dx;
        assign ddx     = sdiff(q_in[i].x, p_in[i].x);
        assign ddy     = sdiff(q_in[i].y, p_in[i].y);
        assign step_dy = {{(EDGE_W-11){ddx[10]}}, ddx};
        assign step_dx = -{{(EDGE_W-11){ddy[10]}}, ddy};

        // Edge accumulator: steps on accept, products in SETUP, walk in SCAN.
        always_ff @(posedge clock) begin
            if (reset) begin
                edges[i] <= '0;
            end else if (!switch_buffer) begin
                if (accept) begin
                    edges[i].dy <= step_dy;
                    edges[i].dx <= step_dx;
                end else if (capture && cap_edge == 2'(i)) begin
                    if (cap_first) begin
                        edges[i].e    <= prod_ext;
                        edges[i].ecol <= prod_ext;
                    end else begin
                        edges[i].e    <= edges[i].e - prod_ext;
                        edges[i].ecol <= edges[i].ecol - prod_ext;
                    end
                end else if (advance) begin
                    if (!row_end) begin
                        edges[i].e <= edges[i].e + edges[i].dy;
                    end else if (!col_end) begin
                        edges[i].ecol <= edges[i].ecol + edges[i].dx;
                        edges[i].e    <= edges[i].ecol + edges[i].dx;
                    end
                end
            end
        end
    end

    // Control FSM with the output register and done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            obj       <= '0;
            xmin      <= '0;
            xmax      <= '0;
            ymin      <= '0;
            ymax      <= '0;
            x         <= '0;
            y         <= '0;
            mul_idx   <= '0;
            pix_out   <= '0;
            pix_valid <= 1'b0;
            task_done <= 1'b0;
        end else if (switch_buffer) begin
            state     <= S_IDLE;
            pix_valid <= 1'b0;
            task_done <= 1'b0;
        end else begin
            task_done <= 1'b0;
            if (pix_valid && pix_ready) begin
                pix_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        obj     <= task_in;
                        xmin    <= in_xmin;
                        xmax    <= in_xmax;
                        ymin    <= in_ymin;
                        ymax    <= in_ymax;
                        x       <= in_xmin;
                        y       <= in_ymin;
                        mul_idx <= '0;
                        state   <= in_empty ? S_DONE : S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (mul_valid) begin
                        if (mul_idx == 3'd5) state <= S_CHECK;
                        else                 mul_idx <= mul_idx + 3'd1;
                    end
                end
                S_CHECK: begin
                    state <= (area2 == '0) ? S_DONE : S_SCAN;
                end
                S_SCAN: begin
                    if (covered && out_free) begin
                        pix_out   <= '{x: x, y: y, red: obj.color.red, green: obj.color.green,
                                       blue: obj.color.blue, depth: obj.depth};
                        pix_valid <= 1'b1;
                    end
                    if (advance) begin
                        if (!row_end) begin
                            y <= y + 10'd1;
                        end else if (!col_end) begin
                            x <= x + 10'd1;
                            y <= ymin;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!pix_valid) begin
                        task_done <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bbox_rasterizer.sv
// Bench for bbox_rasterizer: directed and random triangles, expected pixels
// from a direct per-pixel edge-function model pushed into a queue, and a
// monitor that pops and compares on every output handshake.
module tb_bbox_rasterizer;
  import bbox_rasterizer_pkg::*;

  localparam int PIX_W = $bits(pixel_info_t);
  localparam int X_LO  = 0;
  localparam int X_HI  = 29;
  localparam int Y_HI  = 479;

  logic          clock, reset;
  object_t       task_in;
  logic          task_valid, task_ready, switch_buffer;
  pixel_info_t   pix_out;
  logic          pix_valid, pix_ready, task_done, busy;
  raster_state_t raster_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int exp_done = 0;
  int mul_starts = 0;
  int task_pix = 0;
  int first_x, first_y, last_x, last_y, max_x_seen;
  int ready_mode = 0;
  logic [PIX_W-1:0] exp_q[$];

  bbox_rasterizer #(
    .X_RANGE_START(X_LO), .X_RANGE_END(X_HI), .HEIGHT(Y_HI), .EDGE_W(24)
  ) dut (
    .clock(clock), .reset(reset), .task_in(task_in), .task_valid(task_valid),
    .task_ready(task_ready), .switch_buffer(switch_buffer), .pix_out(pix_out),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .task_done(task_done),
    .busy(busy), .raster_state(raster_state)
  );

  // ---------------- clock / reset block ----------------
  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  // Consumer ready: 0 = always ready, 1 = random 50%, 2 = never ready.
  always @(posedge clock) begin
    #2;
    case (ready_mode)
      0: pix_ready = 1'b1;
      1: pix_ready = ($urandom_range(1, 0) == 1);
      default: pix_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int imin3(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic int imax3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Push every covered pixel of the clipped box, x-major, into exp_q.
  task automatic model_push(input object_t o, output int n);
    int ax, ay, bx, by, cx, cy, area, xl, xh, yl, yh, e0, e1, e2;
    pixel_info_t p;
    ax = int'(o.a.x); ay = int'(o.a.y);
    bx = int'(o.b.x); by = int'(o.b.y);
    cx = int'(o.c.x); cy = int'(o.c.y);
    area = (bx - ax) * (cy - ay) - (by - ay) * (cx - ax);
    xl = imin3(ax, bx, cx); if (xl < X_LO) xl = X_LO;
    xh = imax3(ax, bx, cx); if (xh > X_HI) xh = X_HI;
    yl = imin3(ay, by, cy);
    yh = imax3(ay, by, cy); if (yh > Y_HI) yh = Y_HI;
    n = 0;
    if (area != 0) begin
      for (int px = xl; px <= xh; px++) begin
        for (int py = yl; py <= yh; py++) begin
          e0 = (bx - ax) * (py - ay) - (by - ay) * (px - ax);
          e1 = (cx - bx) * (py - by) - (cy - by) * (px - bx);
          e2 = (ax - cx) * (py - cy) - (ay - cy) * (px - cx);
          if ((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0)) begin
            p.x = 10'(px); p.y = 10'(py);
            p.red = o.color.red; p.green = o.color.green; p.blue = o.color.blue;
            p.depth = o.depth;
            exp_q.push_back(p);
            n++;
          end
        end
      end
    end
  endtask

  function automatic object_t mk_obj(input int ax, input int ay, input int bx, input int by,
                                     input int cx, input int cy);
    object_t o;
    o.a.x = 10'(ax); o.a.y = 10'(ay);
    o.b.x = 10'(bx); o.b.y = 10'(by);
    o.c.x = 10'(cx); o.c.y = 10'(cy);
    o.color.red = 8'($urandom); o.color.green = 8'($urandom); o.color.blue = 8'($urandom);
    o.depth = 16'($urandom);
    return o;
  endfunction

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [PIX_W-1:0] held, want;
    bit hold_v, prev_sw;
    hold_v = 0;
    prev_sw = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (hold_v && !prev_sw) begin
          check("hold_valid", pix_valid, 1'b1);
          check("hold_stable", pix_out, held);
        end
        hold_v  = pix_valid && !pix_ready;
        held    = pix_out;
        prev_sw = switch_buffer;
        if (dut.mul_start) mul_starts++;
        if (pix_valid && pix_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_pixel: got x=%0d y=%0d, expected none", pix_out.x, pix_out.y);
          end else begin
            want = exp_q.pop_front();
            check("pixel", pix_out, want);
          end
          if (task_pix == 0) begin
            first_x = int'(pix_out.x);
            first_y = int'(pix_out.y);
          end
          last_x = int'(pix_out.x);
          last_y = int'(pix_out.y);
          if (int'(pix_out.x) > max_x_seen) max_x_seen = int'(pix_out.x);
          task_pix++;
        end
        if (task_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_task(input object_t o, output int t_acc);
    int n;
    n = 0;
    t_acc = -1;
    @(posedge clock); #1;
    task_in = o;
    task_valid = 1'b1;
    while (t_acc < 0 && n < 200) begin
      @(negedge clock);
      if (task_ready) t_acc = cyc;
      n++;
    end
    @(posedge clock); #1;
    task_valid = 1'b0;
    if (t_acc < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no task_ready, expected accept within 200 cycles");
    end
  endtask

  task automatic wait_done(input int prev, output int d_cyc);
    int n;
    n = 0;
    while (done_cnt == prev && n < 20000) begin
      @(negedge clock);
      n++;
    end
    d_cyc = done_cyc;
    if (done_cnt == prev) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no task_done, expected one within 20000 cycles");
    end
  endtask

  // Issue one task end to end and check pixel count and single done pulse.
  task automatic run_task(input object_t o, output int t_acc, output int d_cyc, output int n_exp);
    int prev;
    prev = done_cnt;
    task_pix = 0;
    max_x_seen = 0;
    model_push(o, n_exp);
    drive_task(o, t_acc);
    wait_done(prev, d_cyc);
    exp_done++;
    repeat (3) @(negedge clock);
    check("pixel_count", task_pix, n_exp);
    check("done_once", done_cnt, prev + 1);
    check("queue_drained", exp_q.size(), 0);
    check("idle_after_done", raster_state, S_IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    object_t o, ob;
    int t_acc, d_cyc, n_exp, prev_mul, prev_done, n;
    reset = 1'b1;
    task_valid = 1'b0;
    task_in = '0;
    switch_buffer = 1'b0;
    pix_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_task_ready", task_ready, 1'b0);
    check("reset_pix_valid", pix_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_task_done", task_done, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    check("ready_after_reset", task_ready, 1'b1);
    check("reset_pix_out", pix_out, 0);
    check("reset_state", raster_state, S_IDLE);

    // Simple cover.
    ready_mode = 0;
    prev_mul = mul_starts;
    o = mk_obj(2, 2, 10, 2, 2, 10);
    run_task(o, t_acc, d_cyc, n_exp);
    check("simple_count45", task_pix, 45);
    check("simple_first_x", first_x, 2);
    check("simple_first_y", first_y, 2);
    check("simple_last_x", last_x, 10);
    check("simple_last_y", last_y, 2);
    check("simple_mul_starts", mul_starts - prev_mul, 6);

    // Opposite winding.
    o = mk_obj(2, 2, 2, 10, 10, 2);
    run_task(o, t_acc, d_cyc, n_exp);
    check("winding_count45", task_pix, 45);

    // Column clipping.
    o = mk_obj(25, 5, 40, 5, 25, 20);
    run_task(o, t_acc, d_cyc, n_exp);
    check("clip_max_x", max_x_seen <= X_HI, 1'b1);

    // Degenerate triangle.
    o = mk_obj(0, 0, 5, 5, 10, 10);
    run_task(o, t_acc, d_cyc, n_exp);
    check("degen_no_pixels", task_pix, 0);
    check("degen_done_latency", d_cyc - t_acc, 9);

    // Empty box to the right of the slice.
    prev_mul = mul_starts;
    o = mk_obj(30, 0, 40, 5, 35, 9);
    run_task(o, t_acc, d_cyc, n_exp);
    check("empty_done_latency", d_cyc - t_acc, 2);
    check("empty_no_multiply", mul_starts - prev_mul, 0);

    // Empty box below the last row.
    o = mk_obj(5, 500, 10, 600, 7, 550);
    run_task(o, t_acc, d_cyc, n_exp);
    check("ybelow_done_latency", d_cyc - t_acc, 2);

    // Back-pressure with random ready: same simple triangle, then randoms.
    ready_mode = 1;
    o = mk_obj(2, 2, 10, 2, 2, 10);
    run_task(o, t_acc, d_cyc, n_exp);
    check("bp_count45", task_pix, 45);
    o = mk_obj(3, 460, 20, 600, 27, 470);
    run_task(o, t_acc, d_cyc, n_exp);
    for (int i = 0; i < 12; i++) begin
      o = mk_obj($urandom_range(45, 0), $urandom_range(40, 0), $urandom_range(45, 0),
                 $urandom_range(40, 0), $urandom_range(45, 0), $urandom_range(40, 0));
      run_task(o, t_acc, d_cyc, n_exp);
    end

    // Abort mid-SCAN with a pending pixel and a competing task.
    ready_mode = 2;
    task_pix = 0;
    prev_done = done_cnt;
    o = mk_obj(2, 2, 10, 2, 2, 10);
    model_push(o, n_exp);
    drive_task(o, t_acc);
    n = 0;
    while (!pix_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("abort_pending_pixel", pix_valid, 1'b1);
    ob = mk_obj(4, 4, 12, 4, 4, 12);
    @(posedge clock); #1;
    switch_buffer = 1'b1;
    task_in = ob;
    task_valid = 1'b1;
    exp_q.delete();
    @(negedge clock);
    check("abort_ready_low", task_ready, 1'b0);
    @(posedge clock); #1;
    switch_buffer = 1'b0;
    model_push(ob, n_exp);
    @(negedge clock);
    check("abort_state_idle", raster_state, S_IDLE);
    check("abort_pix_dropped", pix_valid, 1'b0);
    check("abort_no_done", task_done, 1'b0);
    check("abort_ready_next", task_ready, 1'b1);
    @(posedge clock); #1;
    task_valid = 1'b0;
    ready_mode = 0;
    @(negedge clock);
    check("abort_accepted", raster_state, S_SETUP);
    task_pix = 0;
    wait_done(prev_done, d_cyc);
    exp_done++;
    repeat (3) @(negedge clock);
    check("abort_done_once", done_cnt, prev_done + 1);
    check("abort_pixel_count", task_pix, n_exp);

    // Final report.
    check("total_done", done_cnt, exp_done);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
